// File: rtl/dot_accum.sv
// Dot-product accumulator: sums four Q8.8 product lanes per beat across a vector
// and presents the saturated total, the beat count and an overflow flag.
module dot_accum #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [15:0]      out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s, acc_sat_s;
  logic [15:0]      cnt_r, cnt_s, cnt_sat_s;
  logic             ovf_r, ovf_s, ovf_sat_s;
  logic             accept_s, consume_s, load_s;
  logic [17:0]      lane_sum_s;
  logic [ACC_W:0]   sum_wide_s;

  function automatic logic [17:0] lane_sum(input logic [63:0] d);
    return {2'b00, d[63:48]} + {2'b00, d[47:32]} + {2'b00, d[31:16]} + {2'b00, d[15:0]};
  endfunction

  // Lanes are already Q8.8, so the beat sum adds straight into the accumulator.
  always_comb begin
    state_s    = state_r;
    acc_s      = acc_r;
    cnt_s      = cnt_r;
    ovf_s      = ovf_r;
    load_s     = 1'b0;
    accept_s   = in_valid && (state_r == ACCUM);
    consume_s  = out_ready && (state_r == HOLD);
    lane_sum_s = lane_sum(in_data);
    sum_wide_s = {1'b0, acc_r} + {{(ACC_W-17){1'b0}}, lane_sum_s};
    acc_sat_s  = sum_wide_s[ACC_W] ? {ACC_W{1'b1}} : sum_wide_s[ACC_W-1:0];
    ovf_sat_s  = ovf_r | sum_wide_s[ACC_W];
    cnt_sat_s  = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
    case (state_r)
      ACCUM: begin
        if (accept_s && in_last) begin
          load_s  = 1'b1;
          acc_s   = {ACC_W{1'b0}};
          cnt_s   = 16'd0;
          ovf_s   = 1'b0;
          state_s = HOLD;
        end else if (accept_s) begin
          acc_s   = acc_sat_s;
          cnt_s   = cnt_sat_s;
          ovf_s   = ovf_sat_s;
          state_s = ACCUM;
        end else begin
          state_s = ACCUM;
        end
      end
      HOLD: begin
        if (consume_s) begin
          state_s = ACCUM;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = ACCUM;
    endcase
  end

  assign in_ready = (state_r == ACCUM);

  // State, running totals and the held result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ACCUM;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= 16'd0;
      ovf_r     <= 1'b0;
      out_data  <= {ACC_W{1'b0}};
      out_count <= 16'd0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      ovf_r   <= ovf_s;
      if (load_s) begin
        out_data  <= acc_sat_s;
        out_count <= cnt_sat_s;
        out_ovf   <= ovf_sat_s;
        out_valid <= 1'b1;
      end else if (consume_s) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Bench for dot_accum: a 32-bit and a 20-bit instance share stimulus and are
// checked every cycle against a result-queue model plus directed literals.
module tb_dot_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy32, rdy20, val32, val20, ovf32, ovf20;
  logic [31:0] data32;
  logic [19:0] data20;
  logic [15:0] cnt32, cnt20;

  int passed = 0;
  int total  = 0;

  dot_accum u32 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy32), .out_data(data32), .out_count(cnt32), .out_ovf(ovf32),
    .out_valid(val32), .out_ready(out_ready)
  );

  dot_accum #(.ACC_W(20)) u20 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy20), .out_data(data20), .out_count(cnt20), .out_ovf(ovf20),
    .out_valid(val20), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic longint lanes(input logic [63:0] d);
    return longint'(d[63:48]) + longint'(d[47:32]) + longint'(d[31:16]) + longint'(d[15:0]);
  endfunction

  function automatic longint clip(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Model: a vector is the list of beats taken while no result is waiting;
  // its result is the plain total, clipped to the output width.
  longint m_sum = 0, p_sum = 0;
  int     m_cnt = 0, p_cnt = 0;
  logic   m_pend = 1'b0, m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_sum <= 0; m_cnt <= 0; m_pend <= 1'b0; m_live <= 1'b1;
    end else if (m_pend) begin
      if (out_ready) m_pend <= 1'b0;
    end else if (in_valid) begin
      if (in_last) begin
        p_sum <= m_sum + lanes(in_data);
        p_cnt <= m_cnt + 1;
        m_pend <= 1'b1;
        m_sum <= 0; m_cnt <= 0;
      end else begin
        m_sum <= m_sum + lanes(in_data);
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready32", {63'd0, rdy32}, {63'd0, ~m_pend});
      check("in_ready20", {63'd0, rdy20}, {63'd0, ~m_pend});
      check("out_valid32", {63'd0, val32}, {63'd0, m_pend});
      check("out_valid20", {63'd0, val20}, {63'd0, m_pend});
      if (m_pend) begin
        check("out_data32", {32'd0, data32}, 64'(clip(p_sum, 64'hFFFF_FFFF)));
        check("out_data20", {44'd0, data20}, 64'(clip(p_sum, 64'hF_FFFF)));
        check("out_count32", {48'd0, cnt32}, 64'(clip(longint'(p_cnt), 64'hFFFF)));
        check("out_count20", {48'd0, cnt20}, 64'(clip(longint'(p_cnt), 64'hFFFF)));
        check("out_ovf32", {63'd0, ovf32}, {63'd0, p_sum > 64'hFFFF_FFFF});
        check("out_ovf20", {63'd0, ovf20}, {63'd0, p_sum > 64'hF_FFFF});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic l);
    int n = 0;
    while (!rdy32 && n < 50) begin step(); n++; end
    if (!rdy32) check("beat_wait_timeout", {63'd0, rdy32}, 64'd1);
    in_data = d; in_valid = 1'b1; in_last = l;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    check("reset_out_valid", {63'd0, val32}, 64'd0);
    check("reset_in_ready", {63'd0, rdy32}, 64'd1);
    check("reset_out_data", {32'd0, data32}, 64'd0);

    // Single beat vector.
    out_ready = 1'b1;
    beat(64'h0100_0200_0300_0400, 1'b1);
    check("single_valid", {63'd0, val32}, 64'd1);
    check("single_data", {32'd0, data32}, 64'h0A00);
    check("single_count", {48'd0, cnt32}, 64'd1);
    check("single_ovf", {63'd0, ovf32}, 64'd0);
    step();
    check("single_consumed", {63'd0, val32}, 64'd0);

    // Three beats held under backpressure; HOLD-time beats must be ignored.
    out_ready = 1'b0;
    beat(64'h0100_0100_0100_0100, 1'b0);
    beat(64'h0100_0100_0100_0100, 1'b0);
    beat(64'h0100_0100_0100_0100, 1'b1);
    check("three_data", {32'd0, data32}, 64'h0C00);
    check("three_count", {48'd0, cnt32}, 64'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = 64'hDEAD_BEEF_0000_1111;
      step();
      check("bp_in_ready", {63'd0, rdy32}, 64'd0);
      check("bp_data", {32'd0, data32}, 64'h0C00);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("bp_released", {63'd0, val32}, 64'd0);
    check("bp_ready_back", {63'd0, rdy32}, 64'd1);

    // Saturation on the 20-bit instance, then a clean vector.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("sat_data20", {44'd0, data20}, 64'hF_FFFF);
    check("sat_ovf20", {63'd0, ovf20}, 64'd1);
    check("sat_count20", {48'd0, cnt20}, 64'd5);
    check("sat_data32", {32'd0, data32}, 64'h13_FFEC);
    check("sat_ovf32", {63'd0, ovf32}, 64'd0);
    out_ready = 1'b1;
    step();
    beat(64'h0001_0001_0001_0001, 1'b1);
    check("post_sat_data20", {44'd0, data20}, 64'd4);
    check("post_sat_ovf20", {63'd0, ovf20}, 64'd0);
    step();

    // Reset mid-vector discards the partial sum.
    beat(64'h0100_0100_0100_0100, 1'b0);
    beat(64'h0100_0100_0100_0100, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_no_result", {63'd0, val32}, 64'd0);
    beat(64'h0001_0001_0001_0001, 1'b1);
    check("midrst_data", {32'd0, data32}, 64'd4);
    check("midrst_count", {48'd0, cnt32}, 64'd1);
    step();

    // Reset while a result is held drops it.
    out_ready = 1'b0;
    beat(64'h0000_0000_0000_0007, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    check("holdrst_dropped", {63'd0, val32}, 64'd0);

    // Random valid/ready stress.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
                                              : {16'd0, 16'(i), 16'd3, 16'd1};
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
